inst_encode: RTL and testbench
==============================

Name: inst_encode

Overview:
- Streams decoded instruction fields (iType/aluFunc/brFunc enums from types.svh, plus imm/rs1/rs2/rd) in and emits RV32IM machine words out.
- Writes each word sequentially into instruction memory through a valid/ready write port.
- Used to load test programs into the core's instruction memory from a field-level description.
- Performs the inverse of decode, with an FSM controlling the load session.

Parameters:
- ADDR_WIDTH, 10: width of the word-indexed write address.
- BASE_ADDR, 0: first word address of each load session.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous, active-high
- start_in  input  1  begin a new load session; honoured only in IDLE or DONE
- valid_in  input  1  instruction fields valid
- ready_out  output  1  block accepts fields this cycle
- iType_in  input  4  instruction type enum
- aluFunc_in  input  4  ALU function enum
- brFunc_in  input  3  branch function enum
- imm_in  input  32  immediate, byte offset for B/J
- rs1_in  input  5  source register 1
- rs2_in  input  5  source register 2
- rd_in  input  5  destination register
- last_in  input  1  marks the final instruction of the session
- wr_valid_out  output  1  memory write request
- wr_ready_in  input  1  memory accepts the write
- wr_addr_out  output  ADDR_WIDTH  word address
- wr_data_out  output  32  encoded instruction
- count_out  output  ADDR_WIDTH+1  words written this session
- err_out  output  1  sticky: an illegal field combination was seen
- wrap_out  output  1  sticky: the address wrapped
- done_out  output  1  session complete; level signal

Behaviour:
- Reset: state IDLE. All outputs 0. Any pending write is dropped.
- FSM:
  - IDLE -(start_in)-> LOAD. On entry: addr=BASE_ADDR, count=0, err=0, wrap=0, done=0.
  - LOAD -(accept with last_in)-> DRAIN.
  - DRAIN -(final write handshake)-> DONE.
  - DONE holds done_out=1; start_in returns to LOAD with the entry actions above.
  - start_in in LOAD or DRAIN is ignored.
- Handshakes:
  - ready_out = (state==LOAD) && (!wr_valid_out || wr_ready_in).
  - Accept = valid_in && ready_out.
  - On accept, the encoded word and the current addr are registered into wr_data_out/wr_addr_out and wr_valid_out=1. Latency is 1 cycle.
  - Throughput is 1 word/cycle while wr_ready_in=1.
  - wr_valid_out/wr_addr_out/wr_data_out are held stable until wr_ready_in.
  - A write handshake with no new accept clears wr_valid_out.
  - A simultaneous handshake and accept reloads the register with no bubble.
- Counters:
  - addr increments by 1 per accept and wraps 2^ADDR_WIDTH-1 -> 0.
  - A wrap sets wrap_out, which holds until the next session start.
  - count_out increments per completed write handshake.
- Encoding (RV32IM standard formats):
  - OP: opcode 0110011, funct3/funct7 from aluFunc (Add 000/00, Sub 000/20, Sll 001, Slt 010, Sltu 011, Xor 100, Srl 101/00, Sra 101/20, Or 110, And 111).
  - MUL: opcode 0110011, funct7=01, funct3=000. DIV: funct7=01, funct3=100.
  - OPIMM: opcode 0010011, imm[11:0] in bits 31:20.
    - Shifts put shamt=imm[4:0] in bits 24:20.
    - Sra puts 0100000 in bits 31:25; Sll and Srl put 0000000.
  - LOAD: opcode 0000011, funct3=010. STORE: opcode 0100011, funct3=010, S-split imm.
  - BRANCH: opcode 1100011, funct3 from brFunc (Eq 000, Neq 001, Lt 100, Ge 101, Ltu 110, Geu 111), B-scrambled imm[12:1].
  - JAL: opcode 1101111, J-scrambled imm[20:1].
  - JALR: opcode 1100111, funct3=000.
  - LUI: opcode 0110111, imm[31:12] in bits 31:12. AUIPC: opcode 0010111, same immediate placement.
  - NOP: 0x00000013.
  - Register fields a format does not use are 0.
- Illegal combinations (OP with NoAlu, OPIMM with Sub/NoAlu, BRANCH with Dbr, undefined iType):
  - Emit 0x00000013 and set err_out.
  - The word still occupies an address and is counted.
- Reset mid-session: immediate return to IDLE; no further writes are issued.

Test Plan:
- start, then OP Add rd=3 rs1=1 rs2=2, last=1, wr_ready=1 -> one cycle later wr_valid=1, addr=0, data=0x002081B3; then done_out=1 and count_out=1.
- Stream OPIMM Add rd=1 rs1=0 imm=5; OPIMM Sra rd=1 rs1=1 imm=3; STORE rs1=1 rs2=2 imm=12 -> data 0x00500093, 0x4030D093, 0x0020A623 at addrs 0,1,2 on back-to-back cycles.
- BRANCH Eq rs1=1 rs2=2 imm=8 -> 0x00208463. JAL rd=1 imm=16 -> 0x010000EF. LUI rd=5 imm=0x12345000 -> 0x123452B7.
- Hold wr_ready_in=0 for 3 cycles mid-stream -> ready_out=0, write outputs stable, no word lost or duplicated; count matches the number of inputs.
- BRANCH with Dbr -> data 0x00000013 and err_out=1 sticky; the next start clears it.
- ADDR_WIDTH=2, 5 instructions -> addresses 0,1,2,3,0 and wrap_out=1. Assert rst_in during DRAIN -> all outputs 0 on the next cycle and state IDLE.

Source files
------------

// File: rtl/inst_encode.sv
// rtl/inst_encode.sv - RV32IM field-to-word encoder that streams a program into instruction memory
// Field enums: iType OP=0 OPIMM=1 LOAD=2 STORE=3 BRANCH=4 JAL=5 JALR=6 LUI=7 AUIPC=8 MUL=9 DIV=10 NOP=11.
module inst_encode #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [3:0]            iType_in,
  input  logic [3:0]            aluFunc_in,
  input  logic [2:0]            brFunc_in,
  input  logic [31:0]           imm_in,
  input  logic [4:0]            rs1_in,
  input  logic [4:0]            rs2_in,
  input  logic [4:0]            rd_in,
  input  logic                  last_in,
  output logic                  wr_valid_out,
  input  logic                  wr_ready_in,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [31:0]           wr_data_out,
  output logic [ADDR_WIDTH:0]   count_out,
  output logic                  err_out,
  output logic                  wrap_out,
  output logic                  done_out
);
  localparam logic [3:0] IT_OP = 4'd0, IT_OPIMM = 4'd1, IT_LOAD = 4'd2, IT_STORE = 4'd3,
                         IT_BRANCH = 4'd4, IT_JAL = 4'd5, IT_JALR = 4'd6, IT_LUI = 4'd7,
                         IT_AUIPC = 4'd8, IT_MUL = 4'd9, IT_DIV = 4'd10, IT_NOP = 4'd11;
  // aluFunc 10..15 is NoAlu; brFunc 6..7 is Dbr
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;
  localparam logic [2:0] BR_EQ = 3'd0, BR_NEQ = 3'd1, BR_LT = 3'd2, BR_GE = 3'd3,
                         BR_LTU = 3'd4, BR_GEU = 3'd5;
  localparam logic [31:0]           NOP_WORD = 32'h0000_0013;
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr;
  logic                  accept, wr_hs, session_start, illegal, alu_ok, br_ok;
  logic [2:0]            alu_f3, br_f3;
  logic [6:0]            alu_f7;
  logic [31:0]           word;

  assign ready_out     = (state == LOAD) && (!wr_valid_out || wr_ready_in);
  assign accept        = valid_in && ready_out;
  assign wr_hs         = wr_valid_out && wr_ready_in;
  assign session_start = start_in && ((state == IDLE) || (state == DONE));
  assign done_out      = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in) state_nxt = LOAD;
      LOAD:    if (accept && last_in) state_nxt = DRAIN;
      DRAIN:   if (wr_hs) state_nxt = DONE;
      DONE:    if (start_in) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_f3 = 3'b000;
    alu_f7 = 7'h00;
    alu_ok = 1'b1;
    case (aluFunc_in)
      ALU_ADD:  alu_f3 = 3'b000;
      ALU_SUB:  alu_f7 = 7'h20;
      ALU_SLL:  alu_f3 = 3'b001;
      ALU_SLT:  alu_f3 = 3'b010;
      ALU_SLTU: alu_f3 = 3'b011;
      ALU_XOR:  alu_f3 = 3'b100;
      ALU_SRL:  alu_f3 = 3'b101;
      ALU_SRA:  begin alu_f3 = 3'b101; alu_f7 = 7'h20; end
      ALU_OR:   alu_f3 = 3'b110;
      ALU_AND:  alu_f3 = 3'b111;
      default:  alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    br_f3 = 3'b000;
    br_ok = 1'b1;
    case (brFunc_in)
      BR_EQ:   br_f3 = 3'b000;
      BR_NEQ:  br_f3 = 3'b001;
      BR_LT:   br_f3 = 3'b100;
      BR_GE:   br_f3 = 3'b101;
      BR_LTU:  br_f3 = 3'b110;
      BR_GEU:  br_f3 = 3'b111;
      default: br_ok = 1'b0;
    endcase
  end

  // Illegal combinations fall back to NOP and raise the sticky error
  always_comb begin
    word    = NOP_WORD;
    illegal = 1'b0;
    case (iType_in)
      IT_OP:
        if (alu_ok) word = {alu_f7, rs2_in, rs1_in, alu_f3, rd_in, 7'b0110011};
        else        illegal = 1'b1;
      IT_MUL: word = {7'h01, rs2_in, rs1_in, 3'b000, rd_in, 7'b0110011};
      IT_DIV: word = {7'h01, rs2_in, rs1_in, 3'b100, rd_in, 7'b0110011};
      IT_OPIMM:
        if (!alu_ok || aluFunc_in == ALU_SUB)
          illegal = 1'b1;
        else if (alu_f3 == 3'b001 || alu_f3 == 3'b101)
          word = {alu_f7, imm_in[4:0], rs1_in, alu_f3, rd_in, 7'b0010011};
        else
          word = {imm_in[11:0], rs1_in, alu_f3, rd_in, 7'b0010011};
      IT_LOAD:  word = {imm_in[11:0], rs1_in, 3'b010, rd_in, 7'b0000011};
      IT_STORE: word = {imm_in[11:5], rs2_in, rs1_in, 3'b010, imm_in[4:0], 7'b0100011};
      IT_BRANCH:
        if (br_ok) word = {imm_in[12], imm_in[10:5], rs2_in, rs1_in, br_f3,
                           imm_in[4:1], imm_in[11], 7'b1100011};
        else       illegal = 1'b1;
      IT_JAL:   word = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12], rd_in, 7'b1101111};
      IT_JALR:  word = {imm_in[11:0], rs1_in, 3'b000, rd_in, 7'b1100111};
      IT_LUI:   word = {imm_in[31:12], rd_in, 7'b0110111};
      IT_AUIPC: word = {imm_in[31:12], rd_in, 7'b0010111};
      IT_NOP:   word = NOP_WORD;
      default:  illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_valid_out <= 1'b0;
      wr_addr_out  <= '0;
      wr_data_out  <= '0;
      addr         <= '0;
      count_out    <= '0;
      err_out      <= 1'b0;
      wrap_out     <= 1'b0;
    end else if (session_start) begin
      addr      <= BASE;
      count_out <= '0;
      err_out   <= 1'b0;
      wrap_out  <= 1'b0;
    end else begin
      if (accept) begin
        wr_valid_out <= 1'b1;
        wr_addr_out  <= addr;
        wr_data_out  <= word;
        addr         <= addr + 1'b1;
        if (illegal) err_out  <= 1'b1;
        if (&addr)   wrap_out <= 1'b1;
      end else if (wr_hs) begin
        wr_valid_out <= 1'b0;
      end
      if (wr_hs) count_out <= count_out + 1'b1;
    end
  end
endmodule

// File: tb/tb_inst_encode.sv
// tb/tb_inst_encode.sv - scoreboard bench for inst_encode at ADDR_WIDTH 10 and 2
module tb_inst_encode;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, valid, last, wr_ready;
  logic [3:0] itype, alufunc;
  logic [2:0] brfunc;
  logic [31:0] imm;
  logic [4:0] rs1, rs2, rd;

  logic ready_a, wr_valid_a, err_a, wrap_a, done_a;
  logic [AW-1:0] wr_addr_a;
  logic [31:0] wr_data_a;
  logic [AW:0] count_a;
  logic ready_b, wr_valid_b, err_b, wrap_b, done_b;
  logic [1:0] wr_addr_b;
  logic [31:0] wr_data_b;
  logic [2:0] count_b;

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  typedef struct packed {logic [AW-1:0] addr; logic [31:0] data;} wr_a_t;
  typedef struct packed {logic [1:0] addr; logic [31:0] data;} wr_b_t;
  wr_a_t q_a[$];
  wr_b_t q_b[$];
  logic [AW-1:0] exp_addr_a;
  logic [1:0] exp_addr_b;

  inst_encode #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) u_dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .valid_in(valid), .ready_out(ready_a),
    .iType_in(itype), .aluFunc_in(alufunc), .brFunc_in(brfunc), .imm_in(imm),
    .rs1_in(rs1), .rs2_in(rs2), .rd_in(rd), .last_in(last),
    .wr_valid_out(wr_valid_a), .wr_ready_in(wr_ready), .wr_addr_out(wr_addr_a),
    .wr_data_out(wr_data_a), .count_out(count_a), .err_out(err_a), .wrap_out(wrap_a),
    .done_out(done_a));

  inst_encode #(.ADDR_WIDTH(2), .BASE_ADDR(0)) u_dut2 (
    .clk_in(clk), .rst_in(rst), .start_in(start), .valid_in(valid), .ready_out(ready_b),
    .iType_in(itype), .aluFunc_in(alufunc), .brFunc_in(brfunc), .imm_in(imm),
    .rs1_in(rs1), .rs2_in(rs2), .rd_in(rd), .last_in(last),
    .wr_valid_out(wr_valid_b), .wr_ready_in(wr_ready), .wr_addr_out(wr_addr_b),
    .wr_data_out(wr_data_b), .count_out(count_b), .err_out(err_b), .wrap_out(wrap_b),
    .done_out(done_b));

  // Write-port monitor: a handshake happens at the next posedge when valid and ready are both high
  always @(negedge clk) begin
    if (!rst && wr_ready && wr_valid_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL write_a_unexpected addr=%0d data=%h", wr_addr_a, wr_data_a);
      end else begin
        wr_a_t e;
        e = q_a.pop_front();
        if (wr_addr_a !== e.addr || wr_data_a !== e.data) begin
          errors++;
          $display("FAIL write_a got addr=%0d data=%h want addr=%0d data=%h",
                   wr_addr_a, wr_data_a, e.addr, e.data);
        end
      end
    end
    if (!rst && wr_ready && wr_valid_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL write_b_unexpected addr=%0d data=%h", wr_addr_b, wr_data_b);
      end else begin
        wr_b_t e;
        e = q_b.pop_front();
        if (wr_addr_b !== e.addr || wr_data_b !== e.data) begin
          errors++;
          $display("FAIL write_b got addr=%0d data=%h want addr=%0d data=%h",
                   wr_addr_b, wr_data_b, e.addr, e.data);
        end
      end
    end
  end

  task automatic start_session();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr_a = '0;
    exp_addr_b = '0;
  endtask

  task automatic send(input logic [3:0] t, input logic [3:0] af, input logic [2:0] bf,
                      input logic [31:0] im, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] d, input logic lst, input logic [31:0] exp_word);
    int n = 0;
    itype = t; alufunc = af; brfunc = bf; imm = im;
    rs1 = r1; rs2 = r2; rd = d; last = lst; valid = 1'b1;
    @(negedge clk);
    while (!ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    stalls += n;
    if (!ready_a) begin
      checks++;
      errors++;
      $display("FAIL send_timeout ready=%b want 1", ready_a);
    end else begin
      q_a.push_back('{addr: exp_addr_a, data: exp_word});
      q_b.push_back('{addr: exp_addr_b, data: exp_word});
      exp_addr_a++;
      exp_addr_b++;
    end
    @(posedge clk); #1;
    valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic wait_done(input int exp_count);
    int n = 0;
    while (!(done_a && done_b) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(done_a && done_b)) begin
      errors++;
      $display("FAIL done_timeout done=%b%b want 11", done_a, done_b);
    end
    checks++;
    if (count_a !== (AW+1)'(exp_count) || count_b !== 3'(exp_count)) begin
      errors++;
      $display("FAIL count got %0d/%0d want %0d", count_a, count_b, exp_count);
    end
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL pending_words got %0d/%0d want 0", q_a.size(), q_b.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready_a, wr_valid_a, err_a, wrap_a, done_a} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {ready_a, wr_valid_a, err_a, wrap_a, done_a});
    end
    checks++;
    if (wr_addr_a !== '0 || wr_data_a !== '0 || count_a !== '0) begin
      errors++;
      $display("FAIL reset_values addr=%0d data=%h count=%0d want 0", wr_addr_a, wr_data_a, count_a);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    wr_ready = 1'b1;
    start_session();
    send(4'd0, 4'd0, 3'd0, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h002081B3);
    checks++;
    if (wr_valid_a !== 1'b1 || wr_addr_a !== '0 || wr_data_a !== 32'h002081B3) begin
      errors++;
      $display("FAIL single_latency valid=%b addr=%0d data=%h want 1 0 002081b3",
               wr_valid_a, wr_addr_a, wr_data_a);
    end
    wait_done(1);
    checks++;
    if (err_a !== 1'b0) begin
      errors++;
      $display("FAIL single_err got %b want 0", err_a);
    end
  endtask

  task automatic test_back_to_back();
    wr_ready = 1'b1;
    stalls = 0;
    start_session();
    send(4'd1, 4'd0, 3'd0, 32'd5,  5'd0, 5'd0, 5'd1, 1'b0, 32'h00500093);
    send(4'd1, 4'd7, 3'd0, 32'd3,  5'd1, 5'd0, 5'd1, 1'b0, 32'h4030D093);
    send(4'd3, 4'd0, 3'd0, 32'd12, 5'd1, 5'd2, 5'd0, 1'b1, 32'h0020A623);
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL b2b_stalls got %0d want 0", stalls);
    end
    wait_done(3);
  endtask

  task automatic test_formats();
    wr_ready = 1'b1;
    start_session();
    send(4'd4,  4'd0, 3'd0, 32'd8,         5'd1, 5'd2, 5'd0, 1'b0, 32'h00208463);
    send(4'd5,  4'd0, 3'd0, 32'd16,        5'd0, 5'd0, 5'd1, 1'b0, 32'h010000EF);
    send(4'd7,  4'd0, 3'd0, 32'h12345000,  5'd0, 5'd0, 5'd5, 1'b0, 32'h123452B7);
    send(4'd8,  4'd0, 3'd0, 32'h12345000,  5'd0, 5'd0, 5'd5, 1'b0, 32'h12345297);
    send(4'd2,  4'd0, 3'd0, 32'd8,         5'd2, 5'd0, 5'd4, 1'b0, 32'h00812203);
    send(4'd9,  4'd0, 3'd0, 32'd0,         5'd1, 5'd2, 5'd3, 1'b0, 32'h022081B3);
    send(4'd10, 4'd0, 3'd0, 32'd0,         5'd1, 5'd2, 5'd3, 1'b0, 32'h0220C1B3);
    send(4'd0,  4'd1, 3'd0, 32'd0,         5'd1, 5'd2, 5'd3, 1'b0, 32'h402081B3);
    send(4'd6,  4'd0, 3'd0, 32'd0,         5'd1, 5'd0, 5'd0, 1'b0, 32'h00008067);
    send(4'd11, 4'd0, 3'd0, 32'd0,         5'd0, 5'd0, 5'd0, 1'b1, 32'h00000013);
    wait_done(10);
  endtask

  task automatic test_stall();
    wr_ready = 1'b1;
    start_session();
    send(4'd1, 4'd0, 3'd0, 32'd1, 5'd0, 5'd0, 5'd1, 1'b0, 32'h00100093);
    send(4'd1, 4'd0, 3'd0, 32'd2, 5'd0, 5'd0, 5'd2, 1'b0, 32'h00200113);
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ready_a !== 1'b0 || wr_valid_a !== 1'b1 || wr_addr_a !== AW'(1) ||
          wr_data_a !== 32'h00200113) begin
        errors++;
        $display("FAIL stall_hold ready=%b valid=%b addr=%0d data=%h want 0 1 1 00200113",
                 ready_a, wr_valid_a, wr_addr_a, wr_data_a);
      end
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    send(4'd1, 4'd0, 3'd0, 32'd3, 5'd0, 5'd0, 5'd3, 1'b1, 32'h00300193);
    wait_done(3);
  endtask

  task automatic test_illegal();
    wr_ready = 1'b1;
    start_session();
    send(4'd1,  4'd1, 3'd0, 32'd4, 5'd1, 5'd0, 5'd2, 1'b0, 32'h00000013);
    send(4'd0,  4'd10, 3'd0, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 32'h00000013);
    send(4'd15, 4'd0, 3'd0, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 32'h00000013);
    send(4'd4,  4'd0, 3'd6, 32'd8, 5'd1, 5'd2, 5'd0, 1'b1, 32'h00000013);
    wait_done(4);
    checks++;
    if (err_a !== 1'b1 || err_b !== 1'b1) begin
      errors++;
      $display("FAIL illegal_err got %b%b want 11", err_a, err_b);
    end
    start_session();
    checks++;
    if (err_a !== 1'b0 || done_a !== 1'b0 || count_a !== '0) begin
      errors++;
      $display("FAIL restart_clear err=%b done=%b count=%0d want 0 0 0", err_a, done_a, count_a);
    end
    send(4'd11, 4'd0, 3'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h00000013);
    wait_done(1);
  endtask

  task automatic test_wrap();
    wr_ready = 1'b1;
    start_session();
    for (int i = 0; i < 5; i++)
      send(4'd1, 4'd0, 3'd0, 32'(i), 5'd0, 5'd0, 5'd1, (i == 4), 32'h00000093 | (32'(i) << 20));
    wait_done(5);
    checks++;
    if (wrap_b !== 1'b1 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL wrap got a=%b b=%b want a=0 b=1", wrap_a, wrap_b);
    end
  endtask

  task automatic test_reset_drain();
    wr_ready = 1'b0;
    start_session();
    send(4'd11, 4'd0, 3'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h00000013);
    checks++;
    if (wr_valid_a !== 1'b1 || ready_a !== 1'b0) begin
      errors++;
      $display("FAIL drain_state valid=%b ready=%b want 1 0", wr_valid_a, ready_a);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ready_a, wr_valid_a, err_a, wrap_a, done_a} !== 5'b0 || wr_addr_a !== '0 ||
        wr_data_a !== '0 || count_a !== '0) begin
      errors++;
      $display("FAIL drain_reset flags=%b addr=%0d data=%h count=%0d want all 0",
               {ready_a, wr_valid_a, err_a, wrap_a, done_a}, wr_addr_a, wr_data_a, count_a);
    end
    rst = 1'b0;
    q_a.delete();
    q_b.delete();
    wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_valid_a !== 1'b0 || done_a !== 1'b0 || ready_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset valid=%b done=%b ready=%b want 0 0 0",
               wr_valid_a, done_a, ready_a);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0; wr_ready = 1'b0;
    itype = '0; alufunc = '0; brfunc = '0; imm = '0; rs1 = '0; rs2 = '0; rd = '0;
    exp_addr_a = '0; exp_addr_b = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_formats();
    test_stall();
    test_illegal();
    test_wrap();
    test_reset_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
